hilo_mdu: RTL and testbench



---
 rtl/hilo_mdu.sv | 151 +++++++++++++++
 tb/tb_hilo_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit owning the HI/LO registers.
// Multi-cycle ops compute their result at issue, then hold it until the fixed latency expires.
module hilo_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } mdop_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic        wr_q;
    mdop_e       op;

    assign op = mdop_e'(MDOp);

    logic signed [63:0] prod_s_d;
    logic        [63:0] prod_u_d;

    assign prod_s_d = $signed(A) * $signed(B);
    assign prod_u_d = {32'b0, A} * {32'b0, B};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps naturally back to 0x80000000.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sdiv_den;
    logic [31:0] udiv_den;
    logic [31:0] uq_mag;
    logic [31:0] ur_mag;
    logic [31:0] squot_d;
    logic [31:0] srem_d;
    logic [31:0] uquot_d;
    logic [31:0] urem_d;

    assign a_neg    = A[31];
    assign b_neg    = B[31];
    assign a_mag    = a_neg ? (~A + 32'd1) : A;
    assign b_mag    = b_neg ? (~B + 32'd1) : B;
    assign sdiv_den = (B == '0) ? 32'd1 : b_mag;
    assign udiv_den = (B == '0) ? 32'd1 : B;
    assign uq_mag   = a_mag / sdiv_den;
    assign ur_mag   = a_mag % sdiv_den;
    assign squot_d  = (a_neg ^ b_neg) ? (~uq_mag + 32'd1) : uq_mag;
    assign srem_d   = a_neg ? (~ur_mag + 32'd1) : ur_mag;
    assign uquot_d  = A / udiv_den;
    assign urem_d   = A % udiv_den;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
            busy     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                res_hi_q <= prod_s_d[63:32];
                                res_lo_q <= prod_s_d[31:0];
                                wr_q     <= 1'b1;
                                cnt_q    <= MULT_CNT;
                                busy     <= 1'b1;
                                state_q  <= S_BUSY;
                            end
                            OP_MULTU: begin
                                res_hi_q <= prod_u_d[63:32];
                                res_lo_q <= prod_u_d[31:0];
                                wr_q     <= 1'b1;
                                cnt_q    <= MULT_CNT;
                                busy     <= 1'b1;
                                state_q  <= S_BUSY;
                            end
                            OP_DIV: begin
                                res_hi_q <= srem_d;
                                res_lo_q <= squot_d;
                                wr_q     <= (B != '0);
                                cnt_q    <= DIV_CNT;
                                busy     <= 1'b1;
                                state_q  <= S_BUSY;
                            end
                            OP_DIVU: begin
                                res_hi_q <= urem_d;
                                res_lo_q <= uquot_d;
                                wr_q     <= (B != '0);
                                cnt_q    <= DIV_CNT;
                                busy     <= 1'b1;
                                state_q  <= S_BUSY;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // start is deliberately not examined here
                    if (cnt_q == 4'd1) begin
                        if (wr_q) begin
                            HI <= res_hi_q;
                            LO <= res_lo_q;
                        end
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: a driver queues expected HI/LO per multi-cycle op,
// a monitor checks hold values, busy length and results when busy falls.
module tb_hilo_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    hilo_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } entry_t;

    entry_t      sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          mon_en = 1'b0;
    bit          abort = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics in plain 64-bit integer arithmetic; returns {HI, LO}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] oh,
                                           input logic [31:0] ol);
        longint          sa, sb_, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        res = {oh, ol};
        case (op)
            3'd1: res = sa * sb_;
            3'd2: res = ua * ub;
            3'd3: if (b != 0) begin
                q   = sa / sb_;
                r   = sa % sb_;
                res = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            3'd5: res = {a, ol};
            3'd6: res = {oh, a};
            default: ;
        endcase
        return res;
    endfunction

    // Called at a negedge; returns at the first negedge where the op has fully retired.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] nv;
        entry_t      e;
        int          t;
        bit          multi;
        multi = (op >= 3'd1 && op <= 3'd4);
        nv    = ref_op(op, a, b, m_hi, m_lo);
        start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        if (multi) begin
            e.old_hi = m_hi;
            e.old_lo = m_lo;
            e.hi     = nv[63:32];
            e.lo     = nv[31:0];
            e.cyc    = (op <= 3'd2) ? 5 : 10;
            sb.push_back(e);
        end
        m_hi = nv[63:32];
        m_lo = nv[31:0];
        @(negedge clk);
        start = 1'b0;
        if (multi) begin
            t = 0;
            while (busy && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (busy) check("busy_timeout", 64'(busy), 64'd0);
        end else begin
            check("move_busy", 64'(busy), 64'd0);
            check("move_hi", 64'(HI), 64'(m_hi));
            check("move_lo", 64'(LO), 64'(m_lo));
        end
    endtask

    // Monitor: busy falling is the DUT's "result presented" event.
    initial begin : monitor
        entry_t      e;
        int unsigned bcnt;
        bit          was_busy;
        bcnt     = 0;
        was_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy) begin
                    bcnt++;
                    if (sb.size() > 0) begin
                        check("hold_hi", 64'(HI), 64'(sb[0].old_hi));
                        check("hold_lo", 64'(LO), 64'(sb[0].old_lo));
                    end else begin
                        check("spurious_busy", 64'(busy), 64'd0);
                    end
                end else if (was_busy) begin
                    if (sb.size() == 0) begin
                        check("no_pending_op", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        if (abort) begin
                            check("abort_busy_len", 64'(bcnt), 64'd3);
                            abort = 1'b0;
                        end else begin
                            check("busy_len", 64'(bcnt), 64'(e.cyc));
                            check("res_hi", 64'(HI), 64'(e.hi));
                            check("res_lo", 64'(LO), 64'(e.lo));
                        end
                    end
                end
                if (!busy) bcnt = 0;
                was_busy = busy;
            end
        end
    end

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a, b;
        int          t;
        reset = 1'b1;
        start = 1'b0;
        MDOp  = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        mon_en = 1'b1;

        issue(3'd1, 32'hFFFFFFFD, 32'd5);
        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        issue(3'd5, 32'h00000011, 32'd0);
        issue(3'd6, 32'h00000022, 32'd0);
        issue(3'd4, 32'd7, 32'd0);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        issue(3'd5, 32'hDEADBEEF, 32'd0);
        issue(3'd6, 32'h12345678, 32'd0);
        issue(3'd0, 32'hAAAA5555, 32'd1);
        issue(3'd7, 32'h5555AAAA, 32'd1);
        issue(3'd3, 32'd100, 32'd0);

        // start while busy: must not disturb HI/LO or the pending result
        start = 1'b1; MDOp = 3'd2; A = 32'h00010001; B = 32'h00010001;
        sb.push_back('{m_hi, m_lo, 32'h00000001, 32'h00020001, 5});
        {m_hi, m_lo} = 64'h00000001_00020001;
        @(negedge clk);
        MDOp = 3'd5; A = 32'hCAFEF00D;
        @(negedge clk);
        MDOp = 3'd4; A = 32'd9; B = 32'd2;
        @(negedge clk);
        MDOp = 3'd6; A = 32'h0BADBEEF;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("busy_timeout", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            issue(op, a, b);
        end

        // reset in the third busy cycle aborts the op
        start = 1'b1; MDOp = 3'd1; A = 32'h10; B = 32'h10;
        sb.push_back('{m_hi, m_lo, 32'h0, 32'h100, 5});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        repeat (10) @(negedge clk);
        check("abort_late_lo", 64'(LO), 64'd0);
        check("abort_late_hi", 64'(HI), 64'd0);
        check("abort_late_busy", 64'(busy), 64'd0);

        issue(3'd2, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
